// File: rtl/draw_sched_pkg.sv
// Shared types for the draw command scheduler: command word layout, opcodes, FSM states.
// Consumed by draw_cmd_fifo and draw_cmd_sched.
package draw_sched_pkg;

  typedef enum logic [1:0] {
    NOP     = 2'd0,
    ADD_IMG = 2'd1,
    REM_IMG = 2'd2,
    ADD_FNT = 2'd3
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [4:0] indx;
    logic [5:0] fnt;
    logic [9:0] xloc;
    logic [8:0] yloc;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_e;

  localparam int WDOG_W = 20;

  // WAIT_START gives up after this many quiet cycles have already elapsed (0-based)
  localparam logic [1:0] WS_LAST = 2'd2;

endpackage

// File: rtl/draw_cmd_fifo.sv
// Per-requester command FIFO, head visible combinationally on dout (zero-latency read).
// full blocks further pushes; push and pop in the same cycle both take effect.
module draw_cmd_fifo
  import draw_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/draw_cmd_sched.sv
// Two-port round-robin draw command scheduler feeding the placer; pulse 2 cycles after grant.
// Requesters stall on FIFO full; optional WAIT_DONE watchdog under DRAW_SCHED_WDOG_EN.
module draw_cmd_sched
  import draw_sched_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [19:0] WDOG_LIMIT = 20'hFFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p0_valid,
  output logic       p0_ready,
  input  cmd_t       p0_cmd,
  input  logic       p1_valid,
  output logic       p1_ready,
  input  cmd_t       p1_cmd,
  input  logic       plc_busy,
  output logic       add_img,
  output logic       rem_img,
  output logic       add_fnt,
  output logic [4:0] image_indx,
  output logic [5:0] fnt_indx,
  output logic [9:0] xloc,
  output logic [8:0] yloc,
  output logic       idle,
  output logic       wdog_err
);

  cmd_t   f0_dout;
  cmd_t   f1_dout;
  logic   f0_full;
  logic   f0_empty;
  logic   f1_full;
  logic   f1_empty;
  logic   pop0;
  logic   pop1;
  logic   grant_vld;
  logic   grant_sel;
  cmd_t   grant_cmd;
  state_e state;
  logic   last_grant;
  op_e    op_r;
  logic [1:0] ws_cnt;

  assign p0_ready = !f0_full;
  assign p1_ready = !f1_full;

  draw_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (p0_valid && p0_ready),
    .pop   (pop0),
    .din   (p0_cmd),
    .dout  (f0_dout),
    .full  (f0_full),
    .empty (f0_empty)
  );

  draw_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (p1_valid && p1_ready),
    .pop   (pop1),
    .din   (p1_cmd),
    .dout  (f1_dout),
    .full  (f1_full),
    .empty (f1_empty)
  );

  // grant_sel: 0 = port 0, 1 = port 1; on a tie the port not granted last wins
  always_comb begin
    grant_vld = (state == IDLE) && !plc_busy && (!f0_empty || !f1_empty);
    if (!f0_empty && !f1_empty) begin
      grant_sel = ~last_grant;
    end else begin
      grant_sel = f0_empty;
    end
    grant_cmd = grant_sel ? f1_dout : f0_dout;
  end

  assign pop0 = grant_vld && !grant_sel;
  assign pop1 = grant_vld && grant_sel;
  assign idle = f0_empty && f1_empty && (state == IDLE);

`ifdef DRAW_SCHED_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
`else
  // Limit only matters when the watchdog is built in
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_LIMIT;
  assign wdog_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_r       <= NOP;
      ws_cnt     <= '0;
      add_img    <= 1'b0;
      rem_img    <= 1'b0;
      add_fnt    <= 1'b0;
      image_indx <= '0;
      fnt_indx   <= '0;
      xloc       <= '0;
      yloc       <= '0;
`ifdef DRAW_SCHED_WDOG_EN
      wdog_cnt   <= '0;
      wdog_err   <= 1'b0;
`endif
    end else begin
      add_img <= 1'b0;
      rem_img <= 1'b0;
      add_fnt <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            last_grant <= grant_sel;
            // NOPs are consumed here and never reach the placer
            if (grant_cmd.op != NOP) begin
              op_r       <= grant_cmd.op;
              image_indx <= grant_cmd.indx;
              fnt_indx   <= grant_cmd.fnt;
              xloc       <= grant_cmd.xloc;
              yloc       <= grant_cmd.yloc;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          add_img <= (op_r == ADD_IMG);
          rem_img <= (op_r == REM_IMG);
          add_fnt <= (op_r == ADD_FNT);
          ws_cnt  <= '0;
          state   <= WAIT_START;
        end
        WAIT_START: begin
          if (plc_busy) begin
`ifdef DRAW_SCHED_WDOG_EN
            wdog_cnt <= '0;
`endif
            state <= WAIT_DONE;
          end else if (ws_cnt == WS_LAST) begin
            // placer never started; treat the command as complete
            state <= IDLE;
          end else begin
            ws_cnt <= ws_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!plc_busy) begin
            state <= IDLE;
`ifdef DRAW_SCHED_WDOG_EN
          end else if (wdog_cnt == WDOG_LIMIT) begin
            wdog_err <= 1'b1;
            state    <= IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_cmd_sched.sv
// Bench for draw_cmd_sched: vector table plus hand-written sequences, scoreboard of expected issues.
`timescale 1ns/1ps
module tb_draw_cmd_sched;
  import draw_sched_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       p0_valid = 1'b0;
  logic       p1_valid = 1'b0;
  cmd_t       p0_cmd = '0;
  cmd_t       p1_cmd = '0;
  logic       p0_ready, p1_ready;
  logic       busy_force = 1'b0;
  logic       busy_model = 1'b0;
  logic       plc_busy;
  logic       add_img, rem_img, add_fnt, idle, wdog_err;
  logic [4:0] image_indx;
  logic [5:0] fnt_indx;
  logic [9:0] xloc;
  logic [8:0] yloc;

  assign plc_busy = busy_force | busy_model;

  draw_cmd_sched #(.FIFO_DEPTH(DEPTH), .WDOG_LIMIT(20'd16)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_cmd(p0_cmd),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_cmd(p1_cmd),
    .plc_busy(plc_busy),
    .add_img(add_img), .rem_img(rem_img), .add_fnt(add_fnt),
    .image_indx(image_indx), .fnt_indx(fnt_indx), .xloc(xloc), .yloc(yloc),
    .idle(idle), .wdog_err(wdog_err)
  );

  typedef struct {
    int  port;
    op_e op;
    int  indx;
    int  fnt;
    int  x;
    int  y;
    int  blen;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   pulse_cnt = 0;
  int   busy_len = 0;
  int   busy_left = 0;
  bit   busy_pend = 1'b0;
  cmd_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic cmd_t mk(input op_e op, input int indx, input int fnt, input int x, input int y);
    cmd_t c;
    c.op   = op;
    c.indx = 5'(indx);
    c.fnt  = 6'(fnt);
    c.xloc = 10'(x);
    c.yloc = 9'(y);
    return c;
  endfunction

  // Placer model (busy for busy_len cycles starting one cycle after a pulse) plus issue scoreboard
  task automatic monitor();
    cmd_t e;
    op_e  got;
    forever begin
      @(negedge clk);
      if (busy_pend) begin
        busy_pend = 1'b0;
        if (busy_len > 0) begin
          busy_model = 1'b1;
          busy_left  = busy_len;
        end
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) busy_model = 1'b0;
      end
      if (add_img || rem_img || add_fnt) begin
        pulse_cnt++;
        check("pulse_onehot", 32'(add_img) + 32'(rem_img) + 32'(add_fnt), 32'd1);
        check("pulse_while_busy", 32'(plc_busy), 32'd0);
        check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e   = exp_q.pop_front();
          got = add_img ? ADD_IMG : (rem_img ? REM_IMG : ADD_FNT);
          check("issue_op", 32'(got), 32'(e.op));
          check("issue_fields", 32'({image_indx, fnt_indx, xloc, yloc}),
                32'({e.indx, e.fnt, e.xloc, e.yloc}));
        end
        busy_pend = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    p0_valid   = 1'b0;
    p1_valid   = 1'b0;
    busy_force = 1'b0;
    busy_model = 1'b0;
    busy_left  = 0;
    busy_pend  = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input int port, input cmd_t c, input bit expect_it);
    int   n;
    logic acc;
    n = 0;
    if (port == 0) begin p0_cmd = c; p0_valid = 1'b1; end
    else           begin p1_cmd = c; p1_valid = 1'b1; end
    if (expect_it && c.op != NOP) exp_q.push_back(c);
    do begin
      acc = (port == 0) ? p0_ready : p1_ready;
      @(posedge clk);
      n++;
      if (!acc) @(negedge clk);
    end while (!acc && n < 200);
    @(negedge clk);
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    check("push_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (idle && !plc_busy && !busy_pend && busy_left == 0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_pulse(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (add_img || rem_img || add_fnt) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    cmd_t c;
    cmd_t last_c;
    cmd_t a[3];
    cmd_t b[3];
    int   p;
    bit   seen;

    fork
      monitor();
    join_none

    vt[0] = '{0, ADD_IMG,  2,  0,  100,  50, 10};
    vt[1] = '{1, REM_IMG, 31, 63, 1023, 511,  3};
    vt[2] = '{0, ADD_FNT,  0, 63,    0,   0,  0};
    vt[3] = '{1, NOP,      5,  5,    5,   5,  0};
    vt[4] = '{1, ADD_FNT, 17, 42,  512, 256,  1};
    vt[5] = '{0, REM_IMG,  1,  1,    1,   1,  0};
    vt[6] = '{0, ADD_IMG, 30,  0,  999, 500,  5};
    vt[7] = '{1, NOP,      0,  0,    0,   0,  0};

    // Reset state
    do_reset();
    check("rst_p0_ready", 32'(p0_ready), 32'd1);
    check("rst_p1_ready", 32'(p1_ready), 32'd1);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_fields", 32'({image_indx, fnt_indx, xloc, yloc}), 32'd0);
    check("rst_pulses", 32'({add_img, rem_img, add_fnt}), 32'd0);
    check("rst_wdog", 32'(wdog_err), 32'd0);

    // Single-command vectors
    last_c = '0;
    for (int i = 0; i < 8; i++) begin
      p = pulse_cnt;
      busy_len = vt[i].blen;
      c = mk(vt[i].op, vt[i].indx, vt[i].fnt, vt[i].x, vt[i].y);
      push(vt[i].port, c, 1'b1);
      wait_idle($sformatf("vec%0d_idle", i));
      check($sformatf("vec%0d_pulses", i), 32'(pulse_cnt - p), 32'(vt[i].op != NOP));
      if (vt[i].op != NOP) last_c = c;
      check($sformatf("vec%0d_held", i), 32'({image_indx, fnt_indx, xloc, yloc}),
            32'({last_c.indx, last_c.fnt, last_c.xloc, last_c.yloc}));
    end

    // Contention: three commands per port, round-robin from port 0
    do_reset();
    busy_force = 1'b1;
    busy_len   = 3;
    for (int i = 0; i < 3; i++) begin
      a[i] = mk(ADD_IMG, i, 0, 10 + i, 20 + i);
      b[i] = mk(ADD_FNT, 0, 40 + i, 300 + i, 400 + i);
    end
    for (int i = 0; i < 3; i++) push(0, a[i], 1'b0);
    for (int i = 0; i < 3; i++) push(1, b[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(a[i]);
      exp_q.push_back(b[i]);
    end
    p = pulse_cnt;
    repeat (4) @(negedge clk);
    check("rr_hold_while_busy", 32'(pulse_cnt - p), 32'd0);
    busy_force = 1'b0;
    wait_idle("rr_idle");
    check("rr_pulses", 32'(pulse_cnt - p), 32'd6);

    // Backpressure: fill p0 while the placer is busy
    busy_force = 1'b1;
    busy_len   = 2;
    p = pulse_cnt;
    for (int i = 0; i < 4; i++) push(0, mk(REM_IMG, 8 + i, 0, 50 * i, 7 * i), 1'b1);
    check("bp_full", 32'(p0_ready), 32'd0);
    c = mk(ADD_IMG, 13, 0, 77, 88);
    p0_cmd   = c;
    p0_valid = 1'b1;
    exp_q.push_back(c);
    repeat (3) @(negedge clk);
    check("bp_still_full", 32'(p0_ready), 32'd0);
    check("bp_no_issue", 32'(pulse_cnt - p), 32'd0);
    busy_force = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_after_grant", 32'(p0_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    p0_valid = 1'b0;
    wait_idle("bp_idle");
    check("bp_pulses", 32'(pulse_cnt - p), 32'd5);

    // NOP then REM_IMG with the placer never starting
    busy_len = 0;
    p = pulse_cnt;
    push(0, mk(NOP, 3, 3, 3, 3), 1'b1);
    push(0, mk(REM_IMG, 9, 2, 600, 300), 1'b1);
    wait_pulse("nop_rem_pulse");
    repeat (2) @(negedge clk);
    check("nostart_wait", 32'(idle), 32'd0);
    @(negedge clk);
    check("nostart_idle", 32'(idle), 32'd1);
    check("nop_pulses", 32'(pulse_cnt - p), 32'd1);

    // Reset in WAIT_DONE with two commands queued
    busy_len = 30;
    push(0, mk(ADD_FNT, 4, 21, 111, 222), 1'b1);
    wait_pulse("rstmid_pulse");
    push(0, mk(ADD_IMG, 6, 0, 1, 2), 1'b0);
    push(1, mk(REM_IMG, 7, 0, 3, 4), 1'b0);
    repeat (2) @(negedge clk);
    check("rstmid_busy_phase", 32'(idle), 32'd0);
    do_reset();
    p = pulse_cnt;
    check("rstmid_idle", 32'(idle), 32'd1);
    check("rstmid_ready", 32'({p0_ready, p1_ready}), 32'd3);
    check("rstmid_fields", 32'({image_indx, fnt_indx, xloc, yloc}), 32'd0);
    repeat (20) @(negedge clk);
    check("rstmid_no_pulse", 32'(pulse_cnt - p), 32'd0);
    check("rstmid_idle_late", 32'(idle), 32'd1);

    // Placer stuck busy
    busy_len = 0;
    push(0, mk(ADD_IMG, 11, 0, 12, 13), 1'b1);
    push(1, mk(REM_IMG, 14, 0, 15, 16), 1'b1);
    wait_pulse("wd_pulse");
    @(negedge clk);
    busy_force = 1'b1;
    p = pulse_cnt;
`ifdef DRAW_SCHED_WDOG_EN
    repeat (14) @(negedge clk);
    check("wd_not_yet", 32'(wdog_err), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (wdog_err) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("wd_fired", 32'(seen), 32'd1);
    busy_force = 1'b0;
    busy_len   = 2;
    wait_idle("wd_next_grant");
    check("wd_next_pulse", 32'(pulse_cnt - p), 32'd1);
    check("wd_sticky", 32'(wdog_err), 32'd1);
    do_reset();
    check("wd_cleared", 32'(wdog_err), 32'd0);
`else
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wdog_err || idle) seen = 1'b1;
      @(negedge clk);
    end
    check("wd_off_stays", 32'(seen), 32'd0);
    check("wd_off_no_issue", 32'(pulse_cnt - p), 32'd0);
    busy_force = 1'b0;
    busy_len   = 2;
    wait_idle("wd_off_release");
    check("wd_off_next_pulse", 32'(pulse_cnt - p), 32'd1);
    check("wd_off_err", 32'(wdog_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
